// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transceiver.
//   parity_e          decoded parity mode
//   uart_cfg_t        11-bit runtime configuration word, same bit layout as i_config
//   tx_state_e        transmitter FSM states
//   rx_state_e        receiver FSM states
//   MIN_CLKS_PER_BIT  shortest bit period accepted; shorter requests are clamped
//   bit_period()      effective clocks per bit for a config field
//   decode_parity()   config parity field to parity_e
// The PARITY states are only reachable when UART_PARITY_EN is defined.
package uart_pkg;

  localparam int MIN_CLKS_PER_BIT = 4;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_e;

  typedef struct packed {
    logic [6:0] clks_per_bit;
    logic       two_stop;
    logic [1:0] parity;
    logic       nine_bit;
  } uart_cfg_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_e;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // A zero field selects the default; anything below the minimum is clamped up.
  function automatic logic [6:0] bit_period(input logic [6:0] field, input logic [6:0] dflt);
    logic [6:0] n;
    n = (field == 7'd0) ? dflt : field;
    if (n < 7'(MIN_CLKS_PER_BIT)) n = 7'(MIN_CLKS_PER_BIT);
    return n;
  endfunction

  // Encoding 2'b11 is treated as "no parity".
  function automatic parity_e decode_parity(input logic [1:0] field);
    case (field)
      2'b01:   return PAR_EVEN;
      2'b10:   return PAR_ODD;
      default: return PAR_NONE;
    endcase
  endfunction

endpackage

// File: rtl/uart_transceiver_if.sv
// Host-side parallel interface of the UART transceiver.
//   i_tx_valid, i_tx_parallel[8:0]  TX request and word (host -> UART)
//   o_tx_ready                      transmitter idle (UART -> host)
//   o_rx_parallel[8:0]              last good received word (UART -> host)
//   o_rx_valid, o_rx_error          one-cycle receive status pulses (UART -> host)
// master: host side; slave: UART side.
interface uart_transceiver_if;
  logic       i_tx_valid;
  logic [8:0] i_tx_parallel;
  logic       o_tx_ready;
  logic [8:0] o_rx_parallel;
  logic       o_rx_valid;
  logic       o_rx_error;

  modport master (
    output i_tx_valid, i_tx_parallel,
    input  o_tx_ready, o_rx_parallel, o_rx_valid, o_rx_error
  );

  modport slave (
    input  i_tx_valid, i_tx_parallel,
    output o_tx_ready, o_rx_parallel, o_rx_valid, o_rx_error
  );
endinterface

// File: rtl/uart_rx_engine.sv
// UART receiver: 2-flop synchronizer, start-edge detect, mid-bit sampling,
// framing and (optional) parity checks.
//   i_clk, i_rst          clock, async active-high reset
//   i_rx                  serial input, asynchronous to i_clk
//   i_nine_bit            9 data bits when 1, else 8
//   i_parity              parity mode (port exists only with UART_PARITY_EN)
//   i_clks_per_bit[6:0]   effective bit period, already defaulted and clamped
//   o_rx_parallel[8:0]    last good word, held until the next good frame
//   o_rx_valid            one-cycle pulse with each good frame
//   o_rx_error            one-cycle pulse on bad stop bit or parity mismatch
// Build option: UART_PARITY_EN adds the parity bit check.
//
// state     | meaning
// RX_IDLE   | waiting for a 1->0 edge on the synchronized line
// RX_START  | wait half a bit, confirm start bit is still low
// RX_DATA   | sample data bits LSB-first, one per bit period
// RX_PARITY | sample the parity bit
// RX_STOP   | sample the first stop bit and report the frame
module uart_rx_engine
  import uart_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_rx,
  input  logic       i_nine_bit,
`ifdef UART_PARITY_EN
  input  parity_e    i_parity,
`endif
  input  logic [6:0] i_clks_per_bit,
  output logic [8:0] o_rx_parallel,
  output logic       o_rx_valid,
  output logic       o_rx_error
);

  logic       rx_meta, rx_sync, rx_prev;
  rx_state_e  rx_state, rx_state_nxt;
  logic [6:0] rx_timer, rx_n;
  logic [8:0] rx_shift;
  logic [3:0] rx_bit_cnt;
  logic       rx_nine;
  logic       rx_tc, rx_fall, rx_par_ok;
  logic [3:0] rx_last;
  logic [8:0] rx_word;

`ifdef UART_PARITY_EN
  parity_e    rx_par_mode;
  logic       rx_par_bit;
`endif

  assign rx_tc   = (rx_timer == 7'd0);
  assign rx_fall = rx_prev & ~rx_sync;
  assign rx_last = rx_nine ? 4'd8 : 4'd7;
  // Bits enter at the top; in 8-bit mode the word ends up one place high.
  assign rx_word = rx_nine ? rx_shift : {1'b0, rx_shift[8:1]};

`ifdef UART_PARITY_EN
  always_comb begin
    rx_par_ok = 1'b1;
    case (rx_par_mode)
      PAR_EVEN: rx_par_ok = ~(^rx_word ^ rx_par_bit);
      PAR_ODD:  rx_par_ok =  (^rx_word ^ rx_par_bit);
      default:  rx_par_ok = 1'b1;
    endcase
  end
`else
  assign rx_par_ok = 1'b1;
`endif

  // Reset to idle-high so the first cycles out of reset cannot look like a start edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) rx_state <= RX_IDLE;
    else       rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_state_nxt = RX_START;
      RX_START: if (rx_tc)   rx_state_nxt = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (rx_tc && (rx_bit_cnt == rx_last)) begin
`ifdef UART_PARITY_EN
          rx_state_nxt = (rx_par_mode != PAR_NONE) ? RX_PARITY : RX_STOP;
`else
          rx_state_nxt = RX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      RX_PARITY: if (rx_tc) rx_state_nxt = RX_STOP;
`endif
      RX_STOP:  if (rx_tc) rx_state_nxt = RX_IDLE;
      default:  rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_timer      <= '0;
      rx_n          <= '0;
      rx_shift      <= '0;
      rx_bit_cnt    <= '0;
      rx_nine       <= 1'b0;
      o_rx_parallel <= '0;
      o_rx_valid    <= 1'b0;
      o_rx_error    <= 1'b0;
`ifdef UART_PARITY_EN
      rx_par_mode   <= PAR_NONE;
      rx_par_bit    <= 1'b0;
`endif
    end else begin
      o_rx_valid <= 1'b0;
      o_rx_error <= 1'b0;
      if (rx_state == RX_IDLE) begin
        if (rx_fall) begin
          // First sample lands half a bit after the detected edge.
          rx_timer    <= (i_clks_per_bit >> 1) - 7'd1;
          rx_n        <= i_clks_per_bit;
          rx_nine     <= i_nine_bit;
          rx_bit_cnt  <= '0;
`ifdef UART_PARITY_EN
          rx_par_mode <= i_parity;
`endif
        end
      end else if (rx_tc) begin
        rx_timer <= rx_n - 7'd1;
        case (rx_state)
          RX_DATA: begin
            rx_shift   <= {rx_sync, rx_shift[8:1]};
            rx_bit_cnt <= rx_bit_cnt + 4'd1;
          end
`ifdef UART_PARITY_EN
          RX_PARITY: rx_par_bit <= rx_sync;
`endif
          RX_STOP: begin
            if (rx_sync && rx_par_ok) begin
              o_rx_valid    <= 1'b1;
              o_rx_parallel <= rx_word;
            end else begin
              o_rx_error    <= 1'b1;
            end
          end
          default: ;
        endcase
      end else begin
        rx_timer <= rx_timer - 7'd1;
      end
    end
  end

endmodule

// File: rtl/uart_transceiver.sv
// Full-duplex UART: transmitter FSM here, receiver in uart_rx_engine.
//   i_clk, i_rst   clock, async active-high reset
//   i_config[10:0] [0] 9-bit data, [2:1] parity, [3] two stop bits,
//                  [10:4] clocks per bit (0 = DEFAULT_CLKS_PER_BIT, 1..3 -> 4)
//   i_rx           serial input
//   o_tx           serial output, idle high
//   bus            uart_transceiver_if.slave: TX handshake and RX result/status
// Build option: UART_PARITY_EN enables the parity bit on both directions;
// without it i_config[2:1] is ignored.
//
// state     | meaning
// TX_IDLE   | line high, ready for a word
// TX_START  | start bit (low) for one bit period
// TX_DATA   | data bits LSB-first
// TX_PARITY | parity bit over the data bits
// TX_STOP   | one or two stop bits (high)
module uart_transceiver
  import uart_pkg::*;
#(
  parameter int DEFAULT_CLKS_PER_BIT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [10:0] i_config,
  input  logic        i_rx,
  output logic        o_tx,
  uart_transceiver_if.slave bus
);

  uart_cfg_t  cfg;
  logic [6:0] cfg_n;
  logic [8:0] tx_word_in;

  assign cfg        = uart_cfg_t'(i_config);
  assign cfg_n      = bit_period(cfg.clks_per_bit, 7'(DEFAULT_CLKS_PER_BIT));
  assign tx_word_in = {bus.i_tx_parallel[8] & cfg.nine_bit, bus.i_tx_parallel[7:0]};

`ifdef UART_PARITY_EN
  parity_e cfg_par;
  assign cfg_par = decode_parity(cfg.parity);
`else
  logic unused_parity_cfg;
  assign unused_parity_cfg = ^cfg.parity;
`endif

  tx_state_e  tx_state, tx_state_nxt;
  logic [6:0] tx_timer, tx_n;
  logic [8:0] tx_shift;
  logic [3:0] tx_bit_cnt;
  logic       tx_nine, tx_two_stop, tx_stop_cnt;
  logic       tx_tc;
  logic [3:0] tx_last;

`ifdef UART_PARITY_EN
  logic       tx_par_en, tx_par_bit;
`endif

  assign tx_tc   = (tx_timer == 7'd0);
  assign tx_last = tx_nine ? 4'd8 : 4'd7;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) tx_state <= TX_IDLE;
    else       tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt   = tx_state;
    o_tx           = 1'b1;
    bus.o_tx_ready = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        bus.o_tx_ready = 1'b1;
        if (bus.i_tx_valid) tx_state_nxt = TX_START;
      end
      TX_START: begin
        o_tx = 1'b0;
        if (tx_tc) tx_state_nxt = TX_DATA;
      end
      TX_DATA: begin
        o_tx = tx_shift[0];
        if (tx_tc && (tx_bit_cnt == tx_last)) begin
`ifdef UART_PARITY_EN
          tx_state_nxt = tx_par_en ? TX_PARITY : TX_STOP;
`else
          tx_state_nxt = TX_STOP;
`endif
        end
      end
`ifdef UART_PARITY_EN
      TX_PARITY: begin
        o_tx = tx_par_bit;
        if (tx_tc) tx_state_nxt = TX_STOP;
      end
`endif
      TX_STOP: begin
        if (tx_tc && (tx_stop_cnt || !tx_two_stop)) tx_state_nxt = TX_IDLE;
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  // Word and frame format are captured on acceptance so config changes
  // mid-frame have no effect.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tx_timer    <= '0;
      tx_n        <= '0;
      tx_shift    <= '0;
      tx_bit_cnt  <= '0;
      tx_nine     <= 1'b0;
      tx_two_stop <= 1'b0;
      tx_stop_cnt <= 1'b0;
`ifdef UART_PARITY_EN
      tx_par_en   <= 1'b0;
      tx_par_bit  <= 1'b0;
`endif
    end else if (tx_state == TX_IDLE) begin
      if (bus.i_tx_valid) begin
        tx_shift    <= tx_word_in;
        tx_nine     <= cfg.nine_bit;
        tx_two_stop <= cfg.two_stop;
        tx_n        <= cfg_n;
        tx_timer    <= cfg_n - 7'd1;
        tx_bit_cnt  <= '0;
        tx_stop_cnt <= 1'b0;
`ifdef UART_PARITY_EN
        tx_par_en   <= (cfg_par != PAR_NONE);
        // Bit 8 is already masked in 8-bit mode, so it cannot disturb the XOR.
        tx_par_bit  <= (^tx_word_in) ^ (cfg_par == PAR_ODD);
`endif
      end
    end else if (tx_tc) begin
      tx_timer <= tx_n - 7'd1;
      if (tx_state == TX_DATA) begin
        tx_shift   <= tx_shift >> 1;
        tx_bit_cnt <= tx_bit_cnt + 4'd1;
      end
      if (tx_state == TX_STOP) tx_stop_cnt <= 1'b1;
    end else begin
      tx_timer <= tx_timer - 7'd1;
    end
  end

  uart_rx_engine u_rx (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_rx           (i_rx),
    .i_nine_bit     (cfg.nine_bit),
`ifdef UART_PARITY_EN
    .i_parity       (cfg_par),
`endif
    .i_clks_per_bit (cfg_n),
    .o_rx_parallel  (bus.o_rx_parallel),
    .o_rx_valid     (bus.o_rx_valid),
    .o_rx_error     (bus.o_rx_error)
  );

endmodule

// File: tb/tb_uart_transceiver.sv
`timescale 1ns/1ps
module tb_uart_transceiver;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic [10:0] i_config = '0;
  logic        o_tx;
  logic        i_rx;
  logic        rx_drv = 1'b1;
  logic        loopback = 1'b1;

  uart_transceiver_if bus();

  assign i_rx = loopback ? o_tx : rx_drv;

  uart_transceiver #(.DEFAULT_CLKS_PER_BIT(16)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_config (i_config),
    .i_rx     (i_rx),
    .o_tx     (o_tx),
    .bus      (bus)
  );

  always #5 i_clk = ~i_clk;

  int n_checks = 0;
  int n_pass   = 0;
  int vcnt     = 0;
  int ecnt     = 0;
  logic [8:0] rxq[$];
  logic err_prev = 1'b0;

`ifdef UART_PARITY_EN
  localparam int PAR_BUSY = 176;
`else
  localparam int PAR_BUSY = 160;
`endif

  typedef struct {
    logic [10:0] cfg;
    logic [8:0]  data;
    logic [8:0]  exp_rx;
    int          exp_busy;
  } vec_t;
  vec_t vecs[13];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Receive monitor: counts pulses, records words, checks pulse shape.
  always @(negedge i_clk) begin
    if (i_rst) begin
      err_prev = 1'b0;
    end else begin
      if (bus.o_rx_valid || bus.o_rx_error)
        chk("rx_valid_error_exclusive", int'(bus.o_rx_valid & bus.o_rx_error), 0);
      if (bus.o_rx_error) begin
        chk("rx_error_single_cycle", int'(err_prev), 0);
        ecnt++;
      end
      if (bus.o_rx_valid) begin
        vcnt++;
        rxq.push_back(bus.o_rx_parallel);
      end
      err_prev = bus.o_rx_error;
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [8:0] d);
    int guard = 0;
    while (!bus.o_tx_ready && guard < 3000) begin
      @(negedge i_clk);
      guard++;
    end
    if (!bus.o_tx_ready) chk("tx_ready_wait_timeout", int'(bus.o_tx_ready), 1);
    bus.i_tx_valid    = 1'b1;
    bus.i_tx_parallel = d;
    @(negedge i_clk);
    bus.i_tx_valid    = 1'b0;
  endtask

  // Counts busy cycles after acceptance and the cycle o_rx_valid is seen.
  task automatic run_frame(output int busy, output int lat);
    busy = 0;
    lat  = 0;
    while (!bus.o_tx_ready && busy < 20000) begin
      busy++;
      if (lat == 0 && bus.o_rx_valid) lat = busy;
      @(negedge i_clk);
    end
  endtask

  task automatic drive_frame(input logic [11:0] bits, input int nbits, input int n);
    for (int i = 0; i < nbits; i++) begin
      rx_drv = bits[i];
      repeat (n) @(negedge i_clk);
    end
    rx_drv = 1'b1;
    repeat (3 * n) @(negedge i_clk);
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int busy, lat, v0, e0, q0;
    logic [8:0] words[5];

    vecs[0]  = '{11'h000, 9'h03C, 9'h03C, 160};
    vecs[1]  = '{11'h000, 9'h000, 9'h000, 160};
    vecs[2]  = '{11'h000, 9'h1C3, 9'h0C3, 160};
    vecs[3]  = '{11'h001, 9'h1FF, 9'h1FF, 176};
    vecs[4]  = '{11'h001, 9'h100, 9'h100, 176};
    vecs[5]  = '{11'h008, 9'h081, 9'h081, 176};
    vecs[6]  = '{11'h040, 9'h096, 9'h096, 40};
    vecs[7]  = '{11'h020, 9'h069, 9'h069, 40};
    vecs[8]  = '{11'h010, 9'h05A, 9'h05A, 40};
    vecs[9]  = '{11'h080, 9'h0F0, 9'h0F0, 80};
    vecs[10] = '{11'h002, 9'h007, 9'h007, PAR_BUSY};
    vecs[11] = '{11'h004, 9'h0FF, 9'h0FF, PAR_BUSY};
    vecs[12] = '{11'h7F0, 9'h0A5, 9'h0A5, 1270};

    bus.i_tx_valid    = 1'b0;
    bus.i_tx_parallel = '0;

    // Reset
    repeat (25) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("reset_o_tx", int'(o_tx), 1);
    chk("reset_tx_ready", int'(bus.o_tx_ready), 1);
    chk("reset_rx_parallel", int'(bus.o_rx_parallel), 0);
    chk("reset_rx_valid", int'(bus.o_rx_valid), 0);
    chk("reset_rx_error", int'(bus.o_rx_error), 0);

    // Loopback 8N1 default rate, 0xA5
    v0 = vcnt; e0 = ecnt;
    send(9'h0A5);
    run_frame(busy, lat);
    chk("a5_busy_cycles", busy, 160);
    chk("a5_latency_near_156", int'(lat >= 154 && lat <= 158), 1);
    repeat (40) @(negedge i_clk);
    chk("a5_rx_count", vcnt - v0, 1);
    chk("a5_rx_data", int'(bus.o_rx_parallel), 'h0A5);
    repeat (100) @(negedge i_clk);
    chk("a5_rx_data_stable", int'(bus.o_rx_parallel), 'h0A5);
    chk("a5_rx_errors", ecnt - e0, 0);

    // Table-driven loopback vectors
    foreach (vecs[i]) begin
      i_config = vecs[i].cfg;
      v0 = vcnt; e0 = ecnt;
      send(vecs[i].data);
      run_frame(busy, lat);
      repeat (40) @(negedge i_clk);
      chk($sformatf("vec%0d_busy", i), busy, vecs[i].exp_busy);
      chk($sformatf("vec%0d_rx_count", i), vcnt - v0, 1);
      chk($sformatf("vec%0d_rx_data", i), int'(bus.o_rx_parallel), int'(vecs[i].exp_rx));
      chk($sformatf("vec%0d_rx_errors", i), ecnt - e0, 0);
    end

    // Back-to-back words
    i_config = '0;
    words = '{9'h012, 9'h034, 9'h0C8, 9'h07E, 9'h0E1};
    q0 = rxq.size(); e0 = ecnt;
    for (int i = 0; i < 5; i++) send(words[i]);
    repeat (250) @(negedge i_clk);
    chk("b2b_rx_count", rxq.size() - q0, 5);
    for (int i = 0; i < 5; i++)
      if (rxq.size() > q0 + i) chk($sformatf("b2b_word%0d", i), int'(rxq[q0 + i]), int'(words[i]));
    chk("b2b_rx_errors", ecnt - e0, 0);

    // Valid while busy is ignored
    v0 = vcnt;
    send(9'h011);
    repeat (30) @(negedge i_clk);
    bus.i_tx_valid = 1'b1;
    bus.i_tx_parallel = 9'h022;
    repeat (50) @(negedge i_clk);
    bus.i_tx_valid = 1'b0;
    run_frame(busy, lat);
    repeat (300) @(negedge i_clk);
    chk("busy_ignore_rx_count", vcnt - v0, 1);
    chk("busy_ignore_rx_data", int'(bus.o_rx_parallel), 'h011);

`ifdef UART_PARITY_EN
    // Even parity on the wire, then a frame with a flipped parity bit
    i_config = 11'h002;
    v0 = vcnt; e0 = ecnt;
    send(9'h007);
    repeat (9 * 16 + 8) @(negedge i_clk);
    chk("even_parity_bit_on_tx", int'(o_tx), 1);
    run_frame(busy, lat);
    repeat (40) @(negedge i_clk);
    chk("even_parity_rx_data", int'(bus.o_rx_parallel), 'h007);
    chk("even_parity_rx_count", vcnt - v0, 1);
    loopback = 1'b0;
    v0 = vcnt; e0 = ecnt;
    drive_frame({1'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 16);
    chk("bad_parity_error_count", ecnt - e0, 1);
    chk("bad_parity_rx_count", vcnt - v0, 0);
    chk("bad_parity_rx_data_held", int'(bus.o_rx_parallel), 'h007);
    loopback = 1'b1;
    i_config = '0;
`endif

    // Externally driven frames
    loopback = 1'b0;
    v0 = vcnt; e0 = ecnt;
    drive_frame({2'b00, 1'b1, 8'h4B, 1'b0}, 10, 16);
    chk("ext_good_rx_count", vcnt - v0, 1);
    chk("ext_good_rx_data", int'(bus.o_rx_parallel), 'h04B);
    v0 = vcnt; e0 = ecnt;
    drive_frame({2'b00, 1'b0, 8'h33, 1'b0}, 10, 16);
    chk("bad_stop_error_count", ecnt - e0, 1);
    chk("bad_stop_rx_count", vcnt - v0, 0);
    chk("bad_stop_rx_data_held", int'(bus.o_rx_parallel), 'h04B);

    // One-cycle glitch
    v0 = vcnt; e0 = ecnt;
    rx_drv = 1'b0;
    @(negedge i_clk);
    rx_drv = 1'b1;
    repeat (60) @(negedge i_clk);
    chk("glitch_rx_count", vcnt - v0, 0);
    chk("glitch_error_count", ecnt - e0, 0);
    loopback = 1'b1;

    // Reset in the middle of a frame
    send(9'h03C);
    repeat (40) @(negedge i_clk);
    i_rst = 1'b1;
    #1;
    chk("midreset_o_tx", int'(o_tx), 1);
    chk("midreset_tx_ready", int'(bus.o_tx_ready), 1);
    chk("midreset_rx_parallel", int'(bus.o_rx_parallel), 0);
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    repeat (5) @(negedge i_clk);
    v0 = vcnt;
    send(9'h055);
    run_frame(busy, lat);
    repeat (40) @(negedge i_clk);
    chk("post_reset_busy", busy, 160);
    chk("post_reset_rx_count", vcnt - v0, 1);
    chk("post_reset_rx_data", int'(bus.o_rx_parallel), 'h055);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
